// File: rtl/fib_pkg.sv
// Shared constants for the Fibonacci sequencer FSM and its datapath.
// Opcode encodings, register indices and register-file geometry.
package fib_pkg;

    localparam int NUM_REGS = 4;
    localparam int IDX_W    = 2;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_SET1 = 3'b001;
    localparam logic [2:0] OP_ILL  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_LOAD = 3'b100;
    localparam logic [2:0] OP_TEST = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_MOV  = 3'b111;

    localparam logic [IDX_W-1:0] R0 = 2'd0;
    localparam logic [IDX_W-1:0] R1 = 2'd1;
    localparam logic [IDX_W-1:0] R2 = 2'd2;
    localparam logic [IDX_W-1:0] R3 = 2'd3;

endpackage

// File: rtl/fib_regfile.sv
// Four-entry register file: one write port, two combinational reads.
// Asynchronous active-low clear of all entries.
module fib_regfile
    import fib_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [IDX_W-1:0] raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem [NUM_REGS];

    // Storage update: clear on reset, single write per cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/fib_datapath.sv
// Fibonacci datapath: decode, ALU, flags and result capture.
// FIB_DATAPATH_SAT_EN makes ADD saturate instead of wrap.
module fib_datapath
    import fib_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [2:0]       opcode,
    input  logic [IDX_W-1:0] operand1,
    input  logic [IDX_W-1:0] operand2,
    input  logic             DONE,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic             ZERO_FLAG,
    output logic [WIDTH-1:0] RESULT,
    output logic             RESULT_VALID,
    output logic             OVERFLOW,
    output logic             ILLEGAL
);

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH:0]   sum;
    logic             we;
    logic [WIDTH-1:0] wdata;
    logic             ovf_set;
    logic             ill_set;

    fib_regfile #(
        .WIDTH(WIDTH)
    ) u_rf (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .we     (we),
        .waddr  (operand1),
        .wdata  (wdata),
        .raddr_a(operand1),
        .rdata_a(ra),
        .raddr_b(operand2),
        .rdata_b(rb)
    );

    assign sum = {1'b0, ra} + {1'b0, rb};

    // Decode the current opcode into a register write and flag events.
    always_comb begin
        we      = 1'b0;
        wdata   = '0;
        ovf_set = 1'b0;
        ill_set = 1'b0;
        unique case (1'b1)
            (opcode == OP_NOP): ;
            (opcode == OP_TEST): ;
            (opcode == OP_SET1): begin
                we    = 1'b1;
                wdata = WIDTH'(1);
            end
            (opcode == OP_LOAD): begin
                we    = 1'b1;
                wdata = DATA_IN;
            end
            (opcode == OP_ADD): begin
                we      = 1'b1;
                ovf_set = sum[WIDTH];
`ifdef FIB_DATAPATH_SAT_EN
                wdata   = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
                wdata   = sum[WIDTH-1:0];
`endif
            end
            (opcode == OP_MOV): begin
                we    = 1'b1;
                wdata = rb;
            end
            (opcode == OP_DEC): begin
                we    = 1'b1;
                wdata = ra - WIDTH'(1);
            end
            (opcode == OP_ILL): begin
                ill_set = 1'b1;
            end
            default: ;
        endcase
    end

    assign ZERO_FLAG = (opcode == OP_TEST) && (ra == '0);

    // Sticky error flags; cleared only by reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OVERFLOW <= 1'b0;
            ILLEGAL  <= 1'b0;
        end else begin
            if (ovf_set) OVERFLOW <= 1'b1;
            if (ill_set) ILLEGAL  <= 1'b1;
        end
    end

    // Capture R[operand1] on the first DONE edge; hold while DONE stays.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RESULT       <= '0;
            RESULT_VALID <= 1'b0;
        end else if (DONE && !RESULT_VALID) begin
            RESULT       <= ra;
            RESULT_VALID <= 1'b1;
        end else if (!DONE) begin
            RESULT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fib_datapath.sv
// Self-checking bench for fib_datapath against a behavioural model.
// Covers reset, the Fibonacci loop, wrap/overflow, ILLEGAL and capture.
module tb_fib_datapath;

    localparam int W = 16;

    logic         CLK;
    logic         RST_N;
    logic [2:0]   opcode;
    logic [1:0]   operand1;
    logic [1:0]   operand2;
    logic         DONE;
    logic [W-1:0] DATA_IN;
    logic         ZERO_FLAG;
    logic [W-1:0] RESULT;
    logic         RESULT_VALID;
    logic         OVERFLOW;
    logic         ILLEGAL;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m [4];
    logic [W-1:0] m_res;
    logic         m_rv;
    logic         m_ovf;
    logic         m_ill;

    fib_datapath #(
        .WIDTH(W)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .opcode      (opcode),
        .operand1    (operand1),
        .operand2    (operand2),
        .DONE        (DONE),
        .DATA_IN     (DATA_IN),
        .ZERO_FLAG   (ZERO_FLAG),
        .RESULT      (RESULT),
        .RESULT_VALID(RESULT_VALID),
        .OVERFLOW    (OVERFLOW),
        .ILLEGAL     (ILLEGAL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m[i] = '0;
        m_res = '0;
        m_rv  = 1'b0;
        m_ovf = 1'b0;
        m_ill = 1'b0;
    endtask

    function automatic logic exp_zf();
        return (opcode == 3'b101) && (m[operand1] == '0);
    endfunction

    task automatic drive(input logic [2:0] op, input logic [1:0] a,
                         input logic [1:0] b, input logic d,
                         input logic [W-1:0] din);
        opcode   = op;
        operand1 = a;
        operand2 = b;
        DONE     = d;
        DATA_IN  = din;
        #1;
    endtask

    // Apply the spec rules for the current inputs, then cross the edge.
    task automatic tick();
        int unsigned s;
        if (DONE && !m_rv) begin
            m_res = m[operand1];
            m_rv  = 1'b1;
        end else if (!DONE) begin
            m_rv = 1'b0;
        end
        case (opcode)
            3'b001: m[operand1] = 1;
            3'b100: m[operand1] = DATA_IN;
            3'b111: m[operand1] = m[operand2];
            3'b011: m[operand1] = m[operand1] - 1;
            3'b010: m_ill = 1'b1;
            3'b110: begin
                s = int'(m[operand1]) + int'(m[operand2]);
                if (s > 32'hFFFF) begin
                    m_ovf = 1'b1;
`ifdef FIB_DATAPATH_SAT_EN
                    m[operand1] = 16'hFFFF;
`else
                    m[operand1] = W'(s - 32'h10000);
`endif
                end else begin
                    m[operand1] = W'(s);
                end
            end
            default: ;
        endcase
        @(posedge CLK);
        #1;
    endtask

    task automatic op(input logic [2:0] o, input logic [1:0] a,
                      input logic [1:0] b, input logic [W-1:0] din);
        drive(o, a, b, 1'b0, din);
        tick();
    endtask

    // Present R[idx] on RESULT via a fresh DONE capture.
    task automatic fetch(input logic [1:0] idx);
        drive(3'b000, idx, 2'd0, 1'b0, '0);
        tick();
        drive(3'b000, idx, 2'd0, 1'b1, '0);
        tick();
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        drive(3'b000, 2'd0, 2'd0, 1'b0, '0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        checks++;
        if (RESULT !== '0 || RESULT_VALID !== 1'b0 ||
            OVERFLOW !== 1'b0 || ILLEGAL !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got res=%h rv=%b ovf=%b ill=%b want 0",
                     RESULT, RESULT_VALID, OVERFLOW, ILLEGAL);
        end
        do_reset();
    endtask

    task automatic test_reset_midrun();
        op(3'b100, 2'd0, 2'd0, 16'h1234);
        op(3'b001, 2'd1, 2'd0, '0);
        op(3'b111, 2'd2, 2'd0, '0);
        op(3'b011, 2'd3, 2'd0, '0);
        op(3'b010, 2'd1, 2'd0, '0);
        op(3'b110, 2'd3, 2'd1, '0);
        drive(3'b000, 2'd0, 2'd0, 1'b1, '0);
        tick();
        checks++;
        if (RESULT_VALID !== 1'b1 || OVERFLOW !== 1'b1 ||
            ILLEGAL !== 1'b1 || RESULT !== 16'h1234) begin
            errors++;
            $display("FAIL pre_reset got res=%h rv=%b ovf=%b ill=%b want 1234 1 1 1",
                     RESULT, RESULT_VALID, OVERFLOW, ILLEGAL);
        end
        RST_N = 1'b0;
        drive(3'b101, 2'd0, 2'd0, 1'b0, '0);
        checks++;
        if (RESULT !== '0 || RESULT_VALID !== 1'b0 ||
            OVERFLOW !== 1'b0 || ILLEGAL !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset got res=%h rv=%b ovf=%b ill=%b want 0",
                     RESULT, RESULT_VALID, OVERFLOW, ILLEGAL);
        end
        for (int i = 0; i < 4; i++) begin
            operand1 = 2'(i);
            #1;
            checks++;
            if (ZERO_FLAG !== 1'b1) begin
                errors++;
                $display("FAIL reset_reg%0d_zero got zf=%b want 1", i, ZERO_FLAG);
            end
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        model_reset();
    endtask

    task automatic test_fib_sequence();
        op(3'b100, 2'd0, 2'd0, 16'd5);
        op(3'b001, 2'd1, 2'd0, '0);
        op(3'b001, 2'd2, 2'd0, '0);
        for (int k = 1; k <= 5; k++) begin
            op(3'b111, 2'd3, 2'd1, '0);
            op(3'b110, 2'd1, 2'd2, '0);
            op(3'b111, 2'd2, 2'd3, '0);
            op(3'b011, 2'd0, 2'd0, '0);
            drive(3'b101, 2'd0, 2'd0, 1'b0, '0);
            checks++;
            if (ZERO_FLAG !== (k == 5)) begin
                errors++;
                $display("FAIL fib_loop%0d_zf got %b want %b", k, ZERO_FLAG, k == 5);
            end
            tick();
        end
        drive(3'b101, 2'd1, 2'd0, 1'b1, '0);
        tick();
        checks++;
        if (RESULT !== 16'd13 || RESULT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL fib_result got res=%0d rv=%b want 13 1",
                     RESULT, RESULT_VALID);
        end
        op(3'b000, 2'd0, 2'd0, '0);
    endtask

    task automatic test_zero_count();
        op(3'b001, 2'd0, 2'd0, '0);
        op(3'b100, 2'd0, 2'd0, '0);
        drive(3'b101, 2'd0, 2'd0, 1'b0, '0);
        checks++;
        if (ZERO_FLAG !== 1'b1) begin
            errors++;
            $display("FAIL zero_count_zf got %b want 1", ZERO_FLAG);
        end
        tick();
        drive(3'b101, 2'd0, 2'd0, 1'b0, '0);
        checks++;
        if (ZERO_FLAG !== 1'b1) begin
            errors++;
            $display("FAIL zero_count_after_test got %b want 1", ZERO_FLAG);
        end
        tick();
    endtask

    task automatic test_wrap_overflow();
        do_reset();
        op(3'b011, 2'd0, 2'd0, '0);
        fetch(2'd0);
        checks++;
        if (RESULT !== 16'hFFFF || OVERFLOW !== 1'b0) begin
            errors++;
            $display("FAIL dec_wrap got r0=%h ovf=%b want ffff 0", RESULT, OVERFLOW);
        end
        op(3'b111, 2'd1, 2'd0, '0);
        op(3'b001, 2'd2, 2'd0, '0);
        op(3'b110, 2'd2, 2'd2, '0);
        op(3'b110, 2'd1, 2'd2, '0);
        fetch(2'd1);
        checks++;
`ifdef FIB_DATAPATH_SAT_EN
        if (RESULT !== 16'hFFFF || OVERFLOW !== 1'b1) begin
            errors++;
            $display("FAIL add_sat got r1=%h ovf=%b want ffff 1", RESULT, OVERFLOW);
        end
`else
        if (RESULT !== 16'h0001 || OVERFLOW !== 1'b1) begin
            errors++;
            $display("FAIL add_wrap got r1=%h ovf=%b want 0001 1", RESULT, OVERFLOW);
        end
`endif
    endtask

    task automatic test_illegal();
        do_reset();
        op(3'b001, 2'd1, 2'd0, '0);
        op(3'b010, 2'd1, 2'd0, '0);
        checks++;
        if (ILLEGAL !== 1'b1) begin
            errors++;
            $display("FAIL illegal_set got %b want 1", ILLEGAL);
        end
        op(3'b001, 2'd2, 2'd0, '0);
        op(3'b110, 2'd3, 2'd2, '0);
        fetch(2'd1);
        checks++;
        if (RESULT !== 16'd1 || ILLEGAL !== 1'b1) begin
            errors++;
            $display("FAIL illegal_sticky got r1=%h ill=%b want 0001 1",
                     RESULT, ILLEGAL);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] want [4] = '{16'd2, 16'd2, 16'd2, 16'd2};
        logic         wrv  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        op(3'b001, 2'd1, 2'd0, '0);
        op(3'b001, 2'd2, 2'd0, '0);
        op(3'b110, 2'd1, 2'd2, '0);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) drive(3'b110, 2'd1, 2'd2, 1'b1, '0);
            else        drive(3'b000, 2'd1, 2'd0, c < 3, '0);
            tick();
            checks++;
            if (RESULT !== want[c] || RESULT_VALID !== wrv[c]) begin
                errors++;
                $display("FAIL done_hold_c%0d got res=%h rv=%b want %h %b",
                         c, RESULT, RESULT_VALID, want[c], wrv[c]);
            end
        end
        fetch(2'd1);
        checks++;
        if (RESULT !== 16'd3) begin
            errors++;
            $display("FAIL done_cycle_add got r1=%h want 0003", RESULT);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] din;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       din = '0;
                1:       din = 16'hFFFF;
                default: din = W'($urandom);
            endcase
            drive(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), $urandom_range(0, 5) == 0, din);
            checks++;
            if (ZERO_FLAG !== exp_zf()) begin
                errors++;
                $display("FAIL rand_zf n=%0d got %b want %b", n, ZERO_FLAG, exp_zf());
            end
            tick();
            checks++;
            if (RESULT !== m_res || RESULT_VALID !== m_rv ||
                OVERFLOW !== m_ovf || ILLEGAL !== m_ill) begin
                errors++;
                $display("FAIL rand_state n=%0d got %h %b %b %b want %h %b %b %b",
                         n, RESULT, RESULT_VALID, OVERFLOW, ILLEGAL,
                         m_res, m_rv, m_ovf, m_ill);
            end
        end
    endtask

    initial begin
        RST_N = 1'b0;
        model_reset();
        drive(3'b000, 2'd0, 2'd0, 1'b0, '0);
        test_reset();
        test_reset_midrun();
        test_fib_sequence();
        test_zero_count();
        test_wrap_overflow();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
